// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
//   Packs decoded instruction fields into 32-bit MIPS words and writes them
//   sequentially into instruction memory. It is the inverse of the decode stage
//   and is used to load programs at boot or from the bench.
//
// Ports
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   clear               synchronous restart of count and address
//   in_valid/in_ready   field-bundle handshake (accept = in_valid & in_ready)
//   in_class            0 R,1 LW,2 SW,3 BEQ,4 J,5 JAL,6 ADDI,7 ORI
//   in_rs..in_target    instruction fields; fields a class does not use are ignored
//   imem_we/addr/wdata  registered one-cycle write to instruction memory
//   word_count          words accepted since reset/clear
//   full                word_count == DEPTH
// -----------------------------------------------------------------------------
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              full
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W+1)'(1);

  // Pack one field bundle into its 32-bit machine word.
  function automatic logic [31:0] encode(
    input logic [2:0]  cls,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [5:0]  funct,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] word;
    case (cls)
      3'd0:    word = {6'b000000, rs, rt, rd, shamt, funct};
      3'd1:    word = {6'b100011, rs, rt, imm};
      3'd2:    word = {6'b101011, rs, rt, imm};
      3'd3:    word = {6'b000100, rs, rt, imm};
      3'd4:    word = {6'b000010, target};
      3'd5:    word = {6'b000011, target};
      3'd6:    word = {6'b001000, rs, rt, imm};
      3'd7:    word = {6'b001101, rs, rt, imm};
      default: word = 32'd0;
    endcase
    return word;
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                full_q, full_d;
  logic                ready_s;
  logic                accept_s;

  // Ready is gated by reset so nothing is consumed while the block is held in reset.
  assign ready_s  = reset_n & ~clear & (state_q != ST_FULL);
  assign accept_s = in_valid & ready_s;

  // Next-state, counter and write-port logic.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    full_d  = full_q;
    if (clear) begin
      // A write registered last cycle still issues from the flops; only the
      // session restarts.
      state_d = ST_IDLE;
      count_d = '0;
      full_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_RUN: begin
          if (accept_s) begin
            we_d    = 1'b1;
            // Address wraps naturally in ADDR_W bits.
            addr_d  = BASE_C + count_q[ADDR_W-1:0];
            wdata_d = encode(in_class, in_rs, in_rt, in_rd, in_shamt,
                             in_funct, in_imm, in_target);
            count_d = count_q + ONE_C;
            if (count_d == DEPTH_C) begin
              state_d = ST_FULL;
              full_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_FULL: state_d = ST_FULL;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      full_q  <= full_d;
    end
  end

  assign in_ready   = ready_s;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign word_count = count_q;
  assign full       = full_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder_loader
//   Drives three loader instances (default sizing, DEPTH=4, and a wrapping
//   2-bit address space with BASE_ADDR=3) from one shared stimulus stream.
//   A behavioural model tracks each instance and is compared every cycle;
//   literal expectations pin the model to hand-encoded words.
// -----------------------------------------------------------------------------
module tb_instr_encoder_loader;

  logic        clk;
  logic        reset_n;
  logic        clear;
  logic        in_valid;
  logic [2:0]  in_class;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  logic        a_rdy, a_we, a_full;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata;
  logic [8:0]  a_cnt;
  logic        b_rdy, b_we, b_full;
  logic [7:0]  b_addr;
  logic [31:0] b_wdata;
  logic [8:0]  b_cnt;
  logic        c_rdy, c_we, c_full;
  logic [1:0]  c_addr;
  logic [31:0] c_wdata;
  logic [2:0]  c_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0), .DEPTH(256)) dut_a (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_ready(a_rdy),
    .in_class(in_class), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata), .word_count(a_cnt), .full(a_full));

  instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0), .DEPTH(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_ready(b_rdy),
    .in_class(in_class), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata), .word_count(b_cnt), .full(b_full));

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(3), .DEPTH(4)) dut_c (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_ready(c_rdy),
    .in_class(in_class), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .imem_we(c_we), .imem_addr(c_addr), .imem_wdata(c_wdata), .word_count(c_cnt), .full(c_full));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Per-instance configuration and observed outputs, indexed 0=a, 1=b, 2=c.
  int dep  [3] = '{256, 4, 4};
  int aw   [3] = '{8, 8, 2};
  int base [3] = '{0, 0, 3};
  int opc_tab [8] = '{0, 35, 43, 4, 2, 3, 8, 13};

  wire [31:0] act_we   [3];
  wire [31:0] act_rdy  [3];
  wire [31:0] act_addr [3];
  wire [31:0] act_data [3];
  wire [31:0] act_cnt  [3];
  wire [31:0] act_full [3];
  assign act_we[0]   = {31'd0, a_we};   assign act_we[1]   = {31'd0, b_we};   assign act_we[2]   = {31'd0, c_we};
  assign act_rdy[0]  = {31'd0, a_rdy};  assign act_rdy[1]  = {31'd0, b_rdy};  assign act_rdy[2]  = {31'd0, c_rdy};
  assign act_addr[0] = {24'd0, a_addr}; assign act_addr[1] = {24'd0, b_addr}; assign act_addr[2] = {30'd0, c_addr};
  assign act_data[0] = a_wdata;         assign act_data[1] = b_wdata;         assign act_data[2] = c_wdata;
  assign act_cnt[0]  = {23'd0, a_cnt};  assign act_cnt[1]  = {23'd0, b_cnt};  assign act_cnt[2]  = {29'd0, c_cnt};
  assign act_full[0] = {31'd0, a_full}; assign act_full[1] = {31'd0, b_full}; assign act_full[2] = {31'd0, c_full};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Field layout as arithmetic: opcode*2^26 plus shifted fields.
  function automatic logic [31:0] model_enc(int cls, int rs, int rt, int rd, int sh,
                                            int fn, int imm, int tgt);
    longint w;
    w = longint'(opc_tab[cls]) * 64'd67108864;
    if (cls == 0)
      w = w + rs * 2097152 + rt * 65536 + rd * 2048 + sh * 64 + fn;
    else if (cls == 4 || cls == 5)
      w = w + tgt;
    else
      w = w + rs * 2097152 + rt * 65536 + imm;
    return w[31:0];
  endfunction

  // Model state.
  int          m_cnt  [3];
  bit          m_we   [3];
  int          m_addr [3];
  logic [31:0] m_data [3];
  bit          m_full [3];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        m_cnt[i]  <= 0;
        m_we[i]   <= 1'b0;
        m_addr[i] <= 0;
        m_data[i] <= 32'd0;
        m_full[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (clear) begin
          m_we[i]   <= 1'b0;
          m_cnt[i]  <= 0;
          m_full[i] <= 1'b0;
        end else if (in_valid && m_cnt[i] < dep[i]) begin
          m_we[i]   <= 1'b1;
          m_addr[i] <= (base[i] + m_cnt[i]) % (2 ** aw[i]);
          m_data[i] <= model_enc(int'(in_class), int'(in_rs), int'(in_rt), int'(in_rd),
                                 int'(in_shamt), int'(in_funct), int'(in_imm), int'(in_target));
          m_cnt[i]  <= m_cnt[i] + 1;
          m_full[i] <= (m_cnt[i] + 1 == dep[i]);
        end else begin
          m_we[i] <= 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("we[%0d]", i), act_we[i], {31'd0, m_we[i]});
        check($sformatf("in_ready[%0d]", i), act_rdy[i],
              {31'd0, reset_n && !clear && (m_cnt[i] < dep[i])});
        check($sformatf("word_count[%0d]", i), act_cnt[i], 32'(m_cnt[i]));
        check($sformatf("full[%0d]", i), act_full[i], {31'd0, m_full[i]});
        if (m_we[i]) begin
          check($sformatf("addr[%0d]", i), act_addr[i], 32'(m_addr[i]));
          check($sformatf("wdata[%0d]", i), act_data[i], m_data[i]);
        end
      end
    end
  end

  // One clock of stimulus; returns 2 time units after the rising edge.
  task automatic drive(input logic v, input logic [2:0] cls, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                       input logic [5:0] fn, input logic [15:0] imm,
                       input logic [25:0] tgt, input logic clr);
    in_valid = v; in_class = cls; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_funct = fn; in_imm = imm; in_target = tgt; clear = clr;
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset_n = 1'b0;
    clear = 1'b0; in_valid = 1'b0; in_class = 3'd0; in_rs = 5'd0; in_rt = 5'd0;
    in_rd = 5'd0; in_shamt = 5'd0; in_funct = 6'd0; in_imm = 16'd0; in_target = 26'd0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_we", {31'd0, a_we}, 32'd0);
    check("reset_addr", {24'd0, a_addr}, 32'd0);
    check("reset_wdata", a_wdata, 32'd0);
    check("reset_count", {23'd0, a_cnt}, 32'd0);
    check("reset_full", {31'd0, a_full}, 32'd0);
    check("reset_ready", {31'd0, a_rdy}, 32'd0);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // R-type add $3,$1,$2
    drive(1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0, 1'b0);
    check("r_we", {31'd0, a_we}, 32'd1);
    check("r_addr", {24'd0, a_addr}, 32'd0);
    check("r_wdata", a_wdata, 32'h00221820);
    check("r_model", m_data[0], 32'h00221820);
    check("r_count", {23'd0, a_cnt}, 32'd1);
    check("r_c_addr", {30'd0, c_addr}, 32'd3);

    drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b1);
    check("clr_count", {23'd0, a_cnt}, 32'd0);

    // LW $8,4($29) with junk in unused fields, then JAL 0x0100000
    drive(1'b1, 3'd1, 5'd29, 5'd8, 5'd31, 5'd31, 6'h3F, 16'd4, 26'h3FFFFFF, 1'b0);
    check("lw_addr", {24'd0, a_addr}, 32'd0);
    check("lw_wdata", a_wdata, 32'h8FA80004);
    check("lw_model", m_data[0], 32'h8FA80004);
    check("lw_c_addr", {30'd0, c_addr}, 32'd3);
    drive(1'b1, 3'd5, 5'd7, 5'd7, 5'd7, 5'd7, 6'h11, 16'h1234, 26'h0100000, 1'b0);
    check("jal_we", {31'd0, a_we}, 32'd1);
    check("jal_addr", {24'd0, a_addr}, 32'd1);
    check("jal_wdata", a_wdata, 32'h0C100000);
    check("jal_c_addr", {30'd0, c_addr}, 32'd0);

    drive(1'b1, 3'd6, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h8001, 26'd0, 1'b0);
    check("addi_wdata", a_wdata, 32'h20648001);
    check("addi_c_addr", {30'd0, c_addr}, 32'd1);
    drive(1'b1, 3'd7, 5'd0, 5'd31, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0);
    check("ori_wdata", a_wdata, 32'h341FFFFF);
    check("ori_c_addr", {30'd0, c_addr}, 32'd2);
    check("b_full", {31'd0, b_full}, 32'd1);
    check("b_count4", {23'd0, b_cnt}, 32'd4);
    check("b_ready_full", {31'd0, b_rdy}, 32'd0);

    // Fifth bundle: held by b and c, accepted by a
    drive(1'b1, 3'd2, 5'd2, 5'd9, 5'd0, 5'd0, 6'd0, 16'hFFFC, 26'd0, 1'b0);
    check("b_5th_we", {31'd0, b_we}, 32'd0);
    check("b_5th_count", {23'd0, b_cnt}, 32'd4);
    check("sw_addr", {24'd0, a_addr}, 32'd4);
    check("sw_wdata", a_wdata, 32'hAC49FFFC);

    // clear while full with the bundle still presented
    drive(1'b1, 3'd2, 5'd2, 5'd9, 5'd0, 5'd0, 6'd0, 16'hFFFC, 26'd0, 1'b1);
    check("clrfull_we", {31'd0, a_we}, 32'd0);
    check("clrfull_b_full", {31'd0, b_full}, 32'd0);
    check("clrfull_b_count", {23'd0, b_cnt}, 32'd0);
    drive(1'b1, 3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0);
    check("beq_wdata", a_wdata, 32'h1022FFFF);
    check("beq_b_addr", {24'd0, b_addr}, 32'd0);
    check("beq_c_addr", {30'd0, c_addr}, 32'd3);
    check("beq_count", {23'd0, a_cnt}, 32'd1);

    // clear in the cycle after an accept: the pending write still issues
    drive(1'b1, 3'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h2ABCDEF, 1'b0);
    check("j_wdata", a_wdata, 32'h0AABCDEF);
    drive(1'b1, 3'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h2ABCDEF, 1'b1);
    check("clr_after_we", {31'd0, a_we}, 32'd0);
    check("clr_after_count", {23'd0, a_cnt}, 32'd0);
    drive(1'b1, 3'd0, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 1'b0);
    check("rmax_addr", {24'd0, a_addr}, 32'd0);
    check("rmax_wdata", a_wdata, 32'h03FFFFFF);
    check("rmax_count", {23'd0, a_cnt}, 32'd1);
    check("rmax_c_addr", {30'd0, c_addr}, 32'd3);

    // Reset pulse in the cycle after an accept
    drive(1'b1, 3'd1, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'd8, 26'd0, 1'b0);
    check("pre_rst_we", {31'd0, a_we}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_we", {31'd0, a_we}, 32'd0);
    check("rst_addr", {24'd0, a_addr}, 32'd0);
    check("rst_wdata", a_wdata, 32'd0);
    check("rst_count", {23'd0, a_cnt}, 32'd0);
    check("rst_ready", {31'd0, a_rdy}, 32'd0);
    check("rst_c_wdata", c_wdata, 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
    drive(1'b1, 3'd6, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'd1, 26'd0, 1'b0);
    check("post_rst_addr", {24'd0, a_addr}, 32'd0);
    check("post_rst_wdata", a_wdata, 32'h20010001);
    check("post_rst_count", {23'd0, a_cnt}, 32'd1);
    drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
    drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
